// File: rtl/bcd_to_binary.sv
// Sequential four-digit BCD to 14-bit binary converter, one multiply-accumulate per digit.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  in0,
  input  logic [3:0]  in1,
  input  logic [3:0]  in2,
  input  logic [3:0]  in3,
  output logic        busy,
  output logic        done,
  output logic [13:0] result,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0][3:0]   digits_q, digits_d;
  logic [13:0]       acc_q, acc_d;
  logic [1:0]        idx_q, idx_d;
  logic [13:0]       result_q, result_d;
  logic [17:0]       mac;
  logic              load;

`ifdef BCD_DIGIT_CHECK_EN
  logic              bad_q, bad_d;
  logic              err_q, err_d;

  function automatic logic anyInvalid(input logic [3:0][3:0] d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d[i] > 4'd9) found = 1'b1;
    end
    return found;
  endfunction
`endif

  // Element 0 holds the thousands digit so index order matches processing order.
  assign mac  = ({4'd0, acc_q} * 18'd10) + {14'd0, digits_q[idx_q]};
  assign load = start && (state_q != CONV);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
`ifdef BCD_DIGIT_CHECK_EN
    bad_d    = bad_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: state_d = IDLE;
      CONV: begin
        acc_d = mac[13:0];
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d  = DONE;
`ifdef BCD_DIGIT_CHECK_EN
          result_d = bad_q ? 14'd0 : mac[13:0];
          err_d    = bad_q;
`else
          result_d = mac[13:0];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The DONE cycle may hand straight over to a new conversion for a 5-cycle cadence.
    if (load) begin
      state_d  = CONV;
      digits_d = {in3, in2, in1, in0};
      acc_d    = 14'd0;
      idx_d    = 2'd0;
`ifdef BCD_DIGIT_CHECK_EN
      bad_d    = anyInvalid({in3, in2, in1, in0});
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      acc_q    <= 14'd0;
      idx_q    <= 2'd0;
      result_q <= 14'd0;
`ifdef BCD_DIGIT_CHECK_EN
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
`ifdef BCD_DIGIT_CHECK_EN
      bad_q    <= bad_d;
      err_q    <= err_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed-vector bench for bcd_to_binary with hand-computed results.
// Expectations for invalid digits follow BCD_DIGIT_CHECK_EN.
module tb_bcd_to_binary;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  in0, in1, in2, in3;
  logic        busy, done, err;
  logic [13:0] result;

  int errors = 0;
  int checks = 0;

  bcd_to_binary dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .busy  (busy),
    .done  (done),
    .result(result),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
    in0 = d0; in1 = d1; in2 = d2; in3 = d3;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called just after the accepting edge T; walks T+1..T+5.
  task automatic expectConversion(input string tag, input logic [13:0] expResult, input logic expErr);
    checkOutput({tag, "_busyT"}, busy, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput({tag, "_noDoneEarly"}, done, 0);
    end
    step();
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busyDone"}, busy, 1);
    checkOutput({tag, "_result"}, result, expResult);
    checkOutput({tag, "_err"}, err, expErr);
    step();
    checkOutput({tag, "_donePulse"}, done, 0);
    checkOutput({tag, "_idle"}, busy, 0);
    checkOutput({tag, "_hold"}, result, expResult);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    in0 = 4'd0; in1 = 4'd0; in2 = 4'd0; in3 = 4'd0;
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_err", err, 0);

    applyStimulus(4'd9, 4'd3, 4'd2, 4'd5);
    expectConversion("c9325", 14'd9325, 1'b0);

    // Back-to-back with start held high: accepts at T and T+5.
    in0 = 4'd0; in1 = 4'd0; in2 = 4'd0; in3 = 4'd0;
    start = 1'b1;
    step();
    in0 = 4'd9; in1 = 4'd9; in2 = 4'd9; in3 = 4'd9;
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput("b2b_noDone0", done, 0);
    end
    step();
    checkOutput("b2b_done0", done, 1);
    checkOutput("b2b_result0", result, 0);
    step();
    start = 1'b0;
    checkOutput("b2b_gapDone", done, 0);
    checkOutput("b2b_reaccept", busy, 1);
    checkOutput("b2b_holdZero", result, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput("b2b_noDone1", done, 0);
    end
    step();
    checkOutput("b2b_done1", done, 1);
    checkOutput("b2b_result1", result, 9999);
    step();
    checkOutput("b2b_idle", busy, 0);

    // Start while busy is ignored and not queued.
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    in0 = 4'd8; in1 = 4'd8; in2 = 4'd8; in3 = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("ign_busy", busy, 1);
    step();
    checkOutput("ign_noDone", done, 0);
    step();
    checkOutput("ign_done", done, 1);
    checkOutput("ign_result", result, 1234);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("ign_noSecond", done, 0);
      checkOutput("ign_noBusy", busy, 0);
    end
    checkOutput("ign_hold", result, 1234);

    // Reset mid-conversion aborts it.
    applyStimulus(4'd5, 4'd6, 4'd7, 4'd8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("abort_noDone", done, 0);
    end
    applyStimulus(4'd5, 4'd6, 4'd7, 4'd8);
    expectConversion("c5678", 14'd5678, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
    applyStimulus(4'd1, 4'hA, 4'd0, 4'd0);
    expectConversion("bad1A00", 14'd0, 1'b1);
    applyStimulus(4'd0, 4'd0, 4'd4, 4'd2);
    expectConversion("c0042", 14'd42, 1'b0);
    applyStimulus(4'hF, 4'hF, 4'hF, 4'hF);
    expectConversion("badFFFF", 14'd0, 1'b1);
`else
    applyStimulus(4'd1, 4'hA, 4'd0, 4'd0);
    expectConversion("raw1A00", 14'd2000, 1'b0);
    applyStimulus(4'd0, 4'd0, 4'd4, 4'd2);
    expectConversion("c0042", 14'd42, 1'b0);
    applyStimulus(4'hF, 4'hF, 4'hF, 4'hF);
    expectConversion("rawFFFF", 14'd281, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
